// File: rtl/led_blink_controller.sv
// Multi-channel LED driver: a shared prescaler produces a one-cycle tick.
// Each channel runs OFF, ON, BLINK or PULSE from that tick.
module led_blink_controller #(
    parameter int  NUM_CHANNELS   = 4,
    parameter int  PRESCALE_WIDTH = 25,
    parameter int  PERIOD_WIDTH   = 8,
    localparam int CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PRESCALE_WIDTH-1:0] prescale_div,
    input  logic                      cfg_valid,
    input  logic [CH_W-1:0]           cfg_channel,
    input  logic [1:0]                cfg_mode,
    input  logic [PERIOD_WIDTH-1:0]   cfg_half_period,
    output logic                      tick,
    output logic [NUM_CHANNELS-1:0]   led_out,
    output logic [NUM_CHANNELS-1:0]   busy,
    output logic [2*NUM_CHANNELS-1:0] mode_dbg
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_t;

    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic                      tick_q;

    mode_t                     mode_q [NUM_CHANNELS];
    mode_t                     mode_d [NUM_CHANNELS];
    logic [PERIOD_WIDTH-1:0]   cnt_q  [NUM_CHANNELS];
    logic [PERIOD_WIDTH-1:0]   cnt_d  [NUM_CHANNELS];
    logic [PERIOD_WIDTH-1:0]   half_q [NUM_CHANNELS];
    logic [PERIOD_WIDTH-1:0]   half_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]   led_q, led_d;
    logic [NUM_CHANNELS-1:0]   busy_q, busy_d;

    // ">=" lets a lowered prescale_div take effect on the very next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (pre_cnt >= prescale_div) begin
            pre_cnt <= '0;
            tick_q  <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
            tick_q  <= 1'b0;
        end
    end

    // Config port: cfg_valid is a one-cycle write strobe with no ready; every
    // strobe is accepted. A write beats a same-cycle tick for that channel.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        led_d  = led_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (cfg_valid && (cfg_channel == CH_W'(i))) begin
                mode_d[i] = mode_t'(cfg_mode);
                half_d[i] = cfg_half_period;
                cnt_d[i]  = '0;
                led_d[i]  = (cfg_mode != 2'd0);
                busy_d[i] = (cfg_mode == 2'd3);
            end else if (tick_q) begin
                case (mode_q[i])
                    MODE_OFF: led_d[i] = 1'b0;
                    MODE_ON:  led_d[i] = 1'b1;
                    MODE_BLINK: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i] = '0;
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_WIDTH'(1);
                        end
                    end
                    MODE_PULSE: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            busy_d[i] = 1'b0;
                            mode_d[i] = MODE_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_WIDTH'(1);
                        end
                    end
                    default: led_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= '{default: MODE_OFF};
            cnt_q  <= '{default: '0};
            half_q <= '{default: '0};
            led_q  <= '0;
            busy_q <= '0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            half_q <= half_d;
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        mode_dbg = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mode_dbg[2*i +: 2] = mode_q[i];
        end
    end

    assign tick    = tick_q;
    assign led_out = led_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_blink_controller.sv
// Bench for led_blink_controller: a tick-count model of every channel checked each
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_led_blink_controller;

    // Three channels so that channel index 3 is an out-of-range write target.
    localparam int NC = 3;
    localparam int PW = 25;
    localparam int HW = 8;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [PW-1:0]     prescale_div = PW'(3);
    logic              cfg_valid = 1'b0;
    logic [CW-1:0]     cfg_channel = '0;
    logic [1:0]        cfg_mode = '0;
    logic [HW-1:0]     cfg_half_period = '0;
    logic              tick;
    logic [NC-1:0]     led_out;
    logic [NC-1:0]     busy;
    logic [2*NC-1:0]   mode_dbg;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    led_blink_controller #(
        .NUM_CHANNELS  (NC),
        .PRESCALE_WIDTH(PW),
        .PERIOD_WIDTH  (HW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .prescale_div   (prescale_div),
        .cfg_valid      (cfg_valid),
        .cfg_channel    (cfg_channel),
        .cfg_mode       (cfg_mode),
        .cfg_half_period(cfg_half_period),
        .tick           (tick),
        .led_out        (led_out),
        .busy           (busy),
        .mode_dbg       (mode_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ticks come when more than prescale_div cycles have elapsed since the
    // previous tick (or reset); each channel remembers how many ticks it has seen
    // since its last write, and the LED level follows from that count.
    int cyc = 0;
    int last_evt = 0;
    bit m_tick = 1'b0;
    bit prev_tick;
    int m_mode [NC];
    int m_hp   [NC];
    int m_k    [NC];

    always @(posedge clk) begin
        cyc++;
        prev_tick = m_tick;
        if (reset) begin
            last_evt = cyc;
            m_tick   = 1'b0;
            for (int ch = 0; ch < NC; ch++) begin
                m_mode[ch] = 0;
                m_hp[ch]   = 0;
                m_k[ch]    = 0;
            end
        end else begin
            m_tick = ((cyc - last_evt) > int'(prescale_div));
            if (m_tick) last_evt = cyc;
            for (int ch = 0; ch < NC; ch++) begin
                if (cfg_valid && int'(cfg_channel) == ch) begin
                    m_mode[ch] = int'(cfg_mode);
                    m_hp[ch]   = int'(cfg_half_period);
                    m_k[ch]    = 0;
                end else if (prev_tick) begin
                    if (m_mode[ch] == 2) begin
                        m_k[ch] = (m_k[ch] + 1) % (2 * (m_hp[ch] + 1));
                    end else if (m_mode[ch] == 3) begin
                        m_k[ch]++;
                        if (m_k[ch] > m_hp[ch]) m_mode[ch] = 0;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NC-1:0]   e_led;
            logic [NC-1:0]   e_busy;
            logic [2*NC-1:0] e_mode;
            for (int ch = 0; ch < NC; ch++) begin
                e_led[ch]  = (m_mode[ch] == 1) || (m_mode[ch] == 3) ||
                             ((m_mode[ch] == 2) && (m_k[ch] <= m_hp[ch]));
                e_busy[ch] = (m_mode[ch] == 3);
                e_mode[2*ch +: 2] = 2'(m_mode[ch]);
            end
            check("model_tick", 32'(tick), 32'(m_tick));
            check("model_led", 32'(led_out), 32'(e_led));
            check("model_busy", 32'(busy), 32'(e_busy));
            check("model_mode", 32'(mode_dbg), 32'(e_mode));
        end
    end

    // Driver tasks: called just after a negedge, return just after the next one.
    task automatic cfg_write(input int ch, input int mode, input int hp);
        cfg_valid       = 1'b1;
        cfg_channel     = CW'(ch);
        cfg_mode        = 2'(mode);
        cfg_half_period = HW'(hp);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_tick", 32'(tick), 32'd1);
    endtask

    initial begin
        logic [6:0] pat7;
        logic [5:0] pat6;
        int nb;
        int nl;

        // Reset held for three cycles
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        reset = 1'b0;

        // First tick 4 cycles after release, then every 4th
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t1_tick", 32'(tick), 32'((i % 4) == 0));
        end

        // prescale_div=0, ch1 BLINK half_period=2
        prescale_div = PW'(0);
        repeat (4) @(negedge clk);
        cfg_write(1, 2, 2);
        pat7 = 7'b1110001;
        check("t2_others", 32'({led_out[2], led_out[0]}), 32'd0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            check("t2_blink_ch1", 32'(led_out[1]), 32'(pat7[6-i]));
        end

        // prescale_div=1, ch0 PULSE half_period=3 written on a tick cycle
        cfg_write(1, 0, 0);
        prescale_div = PW'(1);
        repeat (3) @(negedge clk);
        wait_tick();
        cfg_write(0, 3, 3);
        nb = 0;
        nl = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            nb += int'(busy[0]);
            nl += int'(led_out[0]);
        end
        check("t3_busy_cycles", 32'(nb), 32'd8);
        check("t3_led_cycles", 32'(nl), 32'd8);
        check("t3_mode_off", 32'(mode_dbg[1:0]), 32'd0);

        // ch2 BLINK written on a tick while ch0 BLINK runs
        cfg_write(0, 2, 1);
        repeat (3) @(negedge clk);
        wait_tick();
        cfg_write(2, 2, 1);
        pat6 = 6'b111100;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check("t4_blink_ch2", 32'(led_out[2]), 32'(pat6[5-i]));
        end

        // Out-of-range channel write is ignored
        cfg_write(0, 0, 0);
        cfg_write(2, 0, 0);
        check("t5_before", 32'(led_out), 32'd0);
        cfg_write(3, 1, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("t5_ignored_led", 32'(led_out), 32'd0);
        end
        check("t5_ignored_mode", 32'(mode_dbg), 32'd0);
        cfg_write(2, 1, 0);
        check("t5_on_ch2", 32'(led_out), 32'b100);

        // half_period=0: one-tick PULSE, BLINK toggling every tick
        prescale_div = PW'(0);
        repeat (2) @(negedge clk);
        cfg_write(1, 3, 0);
        check("hp0_pulse_on", 32'(busy[1]), 32'd1);
        @(negedge clk);
        check("hp0_pulse_off", 32'({busy[1], led_out[1]}), 32'd0);
        cfg_write(0, 2, 0);
        repeat (4) @(negedge clk);

        // Rewrite during a PULSE replaces it
        prescale_div = PW'(1);
        cfg_write(2, 3, 5);
        repeat (5) @(negedge clk);
        cfg_write(2, 3, 1);
        repeat (10) @(negedge clk);

        // Reset mid-operation aborts pulses and blinks
        cfg_write(1, 3, 20);
        cfg_write(0, 2, 3);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_led", 32'(led_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_mode", 32'(mode_dbg), 32'd0);

        // prescale_div lowered 100 -> 2 while the prescaler sits at 50
        prescale_div = PW'(100);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        prescale_div = PW'(2);
        pat7 = 7'b1001001;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("t6_tick", 32'(tick), 32'(pat7[6-i]));
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
